// File: rtl/sar_search.sv
// Successive-approximation search controller: drives an external comparator
// (trial > target) and resolves the W-bit target MSB first.
module sar_search #(
  parameter int unsigned W       = 4,
  parameter int unsigned CMP_LAT = 0
) (
  input  logic         clk,
  input  logic         reset,
  input  logic         start,
  input  logic         gt,
  output logic [W-1:0] trial,
  output logic         ready,
  output logic         done_tick,
  output logic [W-1:0] result
);

  localparam int unsigned CW = (CMP_LAT > 0) ? $clog2(CMP_LAT + 1) : 1;

  typedef enum logic [1:0] {
    IDLE,
    SEARCH,
    DONE
  } state_t;

  state_t         state;
  logic [W-1:0]   acc;
  logic [W-1:0]   mask;
  logic [CW-1:0]  cnt;

  // mask is zero outside SEARCH, so trial collapses to acc in IDLE and DONE
  assign trial = acc | mask;

  always_ff @(posedge clk) begin
    if (reset) begin
      state     <= IDLE;
      acc       <= '0;
      mask      <= '0;
      cnt       <= '0;
      result    <= '0;
      done_tick <= 1'b0;
      ready     <= 1'b1;
    end else begin
      done_tick <= 1'b0;
      case (state)
        IDLE: begin
          if (start) begin
            acc   <= '0;
            mask  <= W'(1) << (W - 1);
            cnt   <= '0;
            ready <= 1'b0;
            state <= SEARCH;
          end
        end
        SEARCH: begin
          // gt is only trusted on the last cycle of each trial's hold window
          if (cnt == CW'(CMP_LAT)) begin
            cnt  <= '0;
            mask <= mask >> 1;
            if (!gt) begin
              acc <= acc | mask;
            end
            if (mask == W'(1)) begin
              result    <= gt ? acc : (acc | mask);
              done_tick <= 1'b1;
              state     <= DONE;
            end
          end else begin
            cnt <= cnt + CW'(1);
          end
        end
        DONE: begin
          ready <= 1'b1;
          state <= IDLE;
        end
        default: begin
          ready <= 1'b1;
          state <= IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_sar_search.sv
// Self-checking bench for sar_search: three instances (W=4/CMP_LAT=0,
// W=4/CMP_LAT=2, W=1/CMP_LAT=0) driven by directed and random targets.
module tb_sar_search;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic reset;

  logic       start_a, gt_a, ready_a, done_a;
  logic [3:0] trial_a, result_a, tgt_a, last_a;

  logic       start_b, gt_b, ready_b, done_b;
  logic [3:0] trial_b, result_b, last_b;

  logic       start_c, gt_c, ready_c, done_c;
  logic [0:0] trial_c, result_c, tgt_c, last_c;

  int checks = 0;
  int errors = 0;

  sar_search #(.W(4), .CMP_LAT(0)) u_a (
    .clk(clk), .reset(reset), .start(start_a), .gt(gt_a),
    .trial(trial_a), .ready(ready_a), .done_tick(done_a), .result(result_a)
  );

  sar_search #(.W(4), .CMP_LAT(2)) u_b (
    .clk(clk), .reset(reset), .start(start_b), .gt(gt_b),
    .trial(trial_b), .ready(ready_b), .done_tick(done_b), .result(result_b)
  );

  sar_search #(.W(1), .CMP_LAT(0)) u_c (
    .clk(clk), .reset(reset), .start(start_c), .gt(gt_c),
    .trial(trial_c), .ready(ready_c), .done_tick(done_c), .result(result_c)
  );

  // Ideal comparators for the zero-latency instances
  assign gt_a = (trial_a > tgt_a);
  assign gt_c = (trial_c > tgt_c);

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
    end
  endtask

  // Binary-search reference: k-th trial keeps target's bits above the probe bit
  function automatic int exp_trial(input int w, input int k, input int t);
    int m;
    m = 1 << (w - 1 - k);
    return (t & ~((m << 1) - 1)) | m;
  endfunction

  task automatic run_a(input logic [3:0] t);
    tgt_a   = t;
    start_a = 1'b1;
    step();
    start_a = 1'b0;
    for (int k = 0; k < 4; k++) begin
      chk("a_trial", 32'(trial_a), exp_trial(4, k, int'(t)));
      chk("a_ready_search", 32'(ready_a), 0);
      chk("a_done_early", 32'(done_a), 0);
      chk("a_result_hold", 32'(result_a), 32'(last_a));
      step();
    end
    chk("a_done_pulse", 32'(done_a), 1);
    chk("a_result", 32'(result_a), 32'(t));
    chk("a_ready_done", 32'(ready_a), 0);
    last_a = t;
    step();
    chk("a_ready_idle", 32'(ready_a), 1);
    chk("a_done_clear", 32'(done_a), 0);
    chk("a_trial_idle", 32'(trial_a), 32'(t));
  endtask

  // Comparator with CMP_LAT=2 gives the wrong answer for the first two hold cycles
  task automatic run_b(input logic [3:0] t);
    int e;
    start_b = 1'b1;
    step();
    start_b = 1'b0;
    for (int k = 0; k < 4; k++) begin
      e = exp_trial(4, k, int'(t));
      for (int p = 0; p < 3; p++) begin
        chk("b_trial", 32'(trial_b), e);
        chk("b_done_early", 32'(done_b), 0);
        chk("b_result_hold", 32'(result_b), 32'(last_b));
        gt_b = (p < 2) ? !(e > int'(t)) : (e > int'(t));
        step();
      end
    end
    gt_b = 1'b0;
    chk("b_done_pulse", 32'(done_b), 1);
    chk("b_result", 32'(result_b), 32'(t));
    last_b = t;
    step();
    chk("b_ready_idle", 32'(ready_b), 1);
    chk("b_done_clear", 32'(done_b), 0);
  endtask

  task automatic run_c(input logic [0:0] t);
    tgt_c   = t;
    start_c = 1'b1;
    step();
    start_c = 1'b0;
    chk("c_trial", 32'(trial_c), 1);
    chk("c_ready_search", 32'(ready_c), 0);
    chk("c_done_early", 32'(done_c), 0);
    step();
    chk("c_done_pulse", 32'(done_c), 1);
    chk("c_result", 32'(result_c), 32'(t));
    last_c = t;
    step();
    chk("c_ready_idle", 32'(ready_c), 1);
    chk("c_done_clear", 32'(done_c), 0);
  endtask

  initial begin
    reset   = 1'b1;
    start_a = 1'b0; start_b = 1'b0; start_c = 1'b0;
    gt_b    = 1'b0;
    tgt_a   = '0;   tgt_c   = '0;
    last_a  = '0;   last_b  = '0;   last_c  = '0;
    step();
    step();
    reset = 1'b0;

    chk("rst_ready_a", 32'(ready_a), 1);
    chk("rst_done_a", 32'(done_a), 0);
    chk("rst_trial_a", 32'(trial_a), 0);
    chk("rst_result_a", 32'(result_a), 0);
    chk("rst_ready_b", 32'(ready_b), 1);
    chk("rst_result_b", 32'(result_b), 0);
    chk("rst_ready_c", 32'(ready_c), 1);
    chk("rst_result_c", 32'(result_c), 0);

    // Directed target 11 (trials 8,12,10,11), then the extremes and every value
    run_a(4'd11);
    run_a(4'd0);
    run_a(4'd15);
    for (int t = 0; t < 16; t++) run_a(4'(t));
    for (int i = 0; i < 20; i++) run_a(4'($urandom_range(15)));

    // start held high: ignored in SEARCH/DONE, restarts right after IDLE
    tgt_a   = 4'd9;
    start_a = 1'b1;
    step();
    for (int s = 0; s < 2; s++) begin
      for (int k = 0; k < 4; k++) begin
        chk("held_trial", 32'(trial_a), exp_trial(4, k, 9));
        chk("held_ready", 32'(ready_a), 0);
        chk("held_result_hold", 32'(result_a), 32'(last_a));
        step();
      end
      chk("held_done", 32'(done_a), 1);
      chk("held_result", 32'(result_a), 9);
      last_a = 4'd9;
      if (s == 1) start_a = 1'b0;
      step();
      chk("held_ready_idle", 32'(ready_a), 1);
      chk("held_done_clear", 32'(done_a), 0);
      step();
    end
    chk("held_no_third", 32'(ready_a), 1);

    // Reset in cycle 2 of a search abandons it
    tgt_a   = 4'd11;
    start_a = 1'b1;
    step();
    start_a = 1'b0;
    step();
    reset = 1'b1;
    step();
    reset = 1'b0;
    last_a = '0; last_b = '0; last_c = '0;
    chk("mid_rst_ready", 32'(ready_a), 1);
    chk("mid_rst_trial", 32'(trial_a), 0);
    chk("mid_rst_result", 32'(result_a), 0);
    chk("mid_rst_done", 32'(done_a), 0);
    step();
    chk("mid_rst_idle", 32'(ready_a), 1);
    run_a(4'd11);

    // Latency-tolerant instance: target 5 then random targets
    run_b(4'd5);
    for (int i = 0; i < 6; i++) run_b(4'($urandom_range(15)));

    // Single-bit instance
    run_c(1'b1);
    run_c(1'b0);
    for (int i = 0; i < 4; i++) run_c(1'($urandom_range(1)));

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
